// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with a small prefetch queue.
//
// Fetches one word per cycle from a combinational instruction memory into a
// DEPTH-entry FIFO of {pc, instruction}. The consumer drains the head with a
// valid/ready handshake. A redirect flushes the queue and restarts fetch at
// the word-aligned target.
//
// Optional feature macro: FETCH_BOUNDS_CHECK_EN
//   When defined, fetch stops (fault=1) instead of reading past MEM_BYTES.
//   Entries already queued still drain. Only a redirect or reset clears the fault.
//   When undefined, fault is tied low and fetch_pc wraps modulo 2^32.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   DEPTH       prefetch queue entries (2..8)
//   MEM_BYTES   instruction memory size in bytes
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr   out   byte address to instruction memory (= fetch_pc)
//   imem_data   in    instruction word for imem_addr, same cycle
//   ins_valid   out   queue head holds a valid instruction
//   ins_ready   in    consumer accepts head this cycle
//   ins_out     out   instruction at queue head (0 when empty)
//   ins_pc      out   byte address of ins_out (0 when empty)
//   redirect    in    flush queue and refetch from redirect_pc
//   redirect_pc in    new fetch target (low two bits ignored)
//   fault       out   fetch stopped on out-of-range address
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MEM_BYTES = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pc_mem  [DEPTH];
    logic [31:0]        ins_mem [DEPTH];

    logic               pop;
    logic               push_slot;
    logic               out_of_range;
    logic               push;
    logic               enter_fault;
    logic               unused_redir_lsbs;

    // Pointer advance with wrap for non-power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_redir_lsbs = ^redirect_pc[1:0];

    // Handshake and push qualification; redirect overrides both
    assign pop          = ins_valid && ins_ready && !redirect;
    assign push_slot    = (state == ST_FETCH) && !redirect &&
                          ((count < CNT_W'(DEPTH)) || pop);
    // 33-bit compare so a pc near 2^32 cannot wrap into range
    assign out_of_range = ({1'b0, fetch_pc} + 33'd4) > 33'(MEM_BYTES);
    assign enter_fault  = BOUNDS_EN && push_slot && out_of_range;
    assign push         = push_slot && !enter_fault;

    // Control state: pc, pointers, occupancy, fetch/fault state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            state    <= ST_FETCH;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enter_fault) begin
                state <= ST_FAULT;
            end
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= fetch_pc;
            ins_mem[wr_ptr] <= imem_data;
        end
    end

    assign imem_addr = fetch_pc;
    assign ins_valid = (count != '0);
    assign ins_out   = ins_valid ? ins_mem[rd_ptr] : 32'd0;
    assign ins_pc    = ins_valid ? pc_mem[rd_ptr]  : 32'd0;
    assign fault     = BOUNDS_EN && (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl (DEPTH=2, RESET_PC=0, MEM_BYTES=400).
// Memory model returns the word's own address, so ins_out must equal ins_pc.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .MEM_BYTES (400)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_out     (ins_out),
        .ins_pc      (ins_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    assign imem_data = imem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Monitor: every accepted head must match the next expected pc/word
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n && ins_valid && ins_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ins: got pc %h ins %h expected none", ins_pc, ins_out);
            end else begin
                e = exp_q.pop_front();
                chk("ins_pc", ins_pc, e);
                chk("ins_out", ins_out, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        ins_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        tick(2);

        // Reset state
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins_out", ins_out, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);

        // Streaming one per cycle from the first edge after reset release
        push_stream(32'd0, 9);
        rst_n = 1'b1;
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        chk("midrst_valid", 32'(ins_valid), 32'd0);
        chk("midrst_imem_addr", imem_addr, 32'd0);

        // Backpressure: queue saturates at 2, head stable
        ins_ready = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("bp_valid", 32'(ins_valid), 32'd1);
            chk("bp_head_pc", ins_pc, 32'd0);
        end
        chk("bp_imem_addr", imem_addr, 32'd8);
        chk("bp_head_ins", ins_out, 32'd0);
        ins_ready = 1'b1;
        push_stream(32'd0, 6);
        tick(6);
        ins_ready = 1'b0;
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Redirect while full: old entries discarded, misaligned target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_006E;
        tick(1);
        chk("redir_valid", 32'(ins_valid), 32'd0);
        chk("redir_imem_addr", imem_addr, 32'h0000_006C);
        redirect  = 1'b0;
        ins_ready = 1'b1;
        push_stream(32'h0000_006C, 3);
        tick(4);
        ins_ready = 1'b0;
        chk("redir_drained", 32'(exp_q.size()), 32'd0);
        tick(2);
        chk("full_imem_addr", imem_addr, 32'h0000_0080);
        chk("full_head_pc", ins_pc, 32'h0000_0078);

        // Asynchronous reset with queue full, then restart at RESET_PC
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ins_valid), 32'd0);
        chk("arst_imem_addr", imem_addr, 32'd0);
        chk("arst_ins_pc", ins_pc, 32'd0);
        chk("arst_ins_out", ins_out, 32'd0);
        ins_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick(1);
        chk("rst_ignores_redir", imem_addr, 32'd0);
        redirect = 1'b0;
        push_stream(32'd0, 3);
        rst_n = 1'b1;
        tick(4);
        ins_ready = 1'b0;
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        // Fetch near the top of memory
        redirect    = 1'b1;
        redirect_pc = 32'd392;
        ins_ready   = 1'b1;
        tick(1);
        redirect = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        push_stream(32'd392, 2);
        tick(3);
        chk("bnd_fault", 32'(fault), 32'd1);
        chk("bnd_valid", 32'(ins_valid), 32'd0);
        chk("bnd_drained", 32'(exp_q.size()), 32'd0);
        tick(1);
        chk("bnd_fault_hold", 32'(fault), 32'd1);
        chk("bnd_imem_addr", imem_addr, 32'd400);
        ins_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'd0;
        tick(1);
        chk("bnd_fault_clr", 32'(fault), 32'd0);
        redirect = 1'b0;
        tick(1);
        chk("bnd_resume_valid", 32'(ins_valid), 32'd1);
        chk("bnd_resume_pc", ins_pc, 32'd0);
`else
        push_stream(32'd392, 4);
        tick(5);
        chk("nobnd_fault", 32'(fault), 32'd0);
        chk("nobnd_drained", 32'(exp_q.size()), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick(1);
        redirect = 1'b0;
        push_stream(32'hFFFF_FFFC, 3);
        tick(4);
        ins_ready = 1'b0;
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);
        chk("wrap_fault", 32'(fault), 32'd0);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
